// File: rtl/pipe_run_controller.sv
// Debug run controller for the pipelined core: single-step, free-run and PC breakpoint,
// plus executed/fetch cycle counters. Optional RUN burst watchdog under RUN_WATCHDOG_EN.
module pipe_run_controller #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RUN_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_req,
  input  logic             run_req,
  input  logic             clr_count,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             stall_f,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic             wd_halt,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_STEP,
    ST_RUN,
    ST_BREAK
  } state_e;

  state_e            state_q, state_d;
  logic              skip_q, skip_d;
  logic              bp_match;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  fetch_q, fetch_d;

`ifdef RUN_WATCHDOG_EN
  localparam int unsigned BURST_W = $clog2(RUN_LIMIT + 1);
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               wd_q, wd_d;
`endif

  // skip masks the breakpoint so the core can step off bp_addr once after BREAK
  assign bp_match = bp_en & (pc == bp_addr) & ~skip_q;

  // Next-state, skip flag and the combinational clock enable
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cpu_en  = 1'b0;
`ifdef RUN_WATCHDOG_EN
    wd_d    = 1'b0;
`endif
    unique case (state_q)
      ST_HALT: begin
        if (run_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        cpu_en = 1'b1;
        if (!stall_f) begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        cpu_en = ~bp_match;
        if (bp_match) begin
          state_d = ST_BREAK;
        end else if (run_req) begin
          state_d = ST_HALT;
`ifdef RUN_WATCHDOG_EN
        end else if (burst_q == BURST_W'(RUN_LIMIT - 1)) begin
          state_d = ST_HALT;
          wd_d    = 1'b1;
`endif
        end
      end
      ST_BREAK: begin
        if (run_req) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_req) begin
          state_d = ST_STEP;
          skip_d  = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (cpu_en && !stall_f) begin
      skip_d = 1'b0;
    end
  end

  // Counters: clear beats a same-cycle increment, wrap is silent
  always_comb begin
    cyc_d   = cyc_q;
    fetch_d = fetch_q;
    if (clr_count) begin
      cyc_d   = '0;
      fetch_d = '0;
    end else if (cpu_en) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (!stall_f) begin
        fetch_d = fetch_q + CNT_W'(1);
      end
    end
  end

`ifdef RUN_WATCHDOG_EN
  // Burst counter only lives while RUN persists; any exit or fresh entry zeroes it
  always_comb begin
    burst_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      burst_d = cpu_en ? burst_q + BURST_W'(1) : burst_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_q <= '0;
      wd_q    <= 1'b0;
    end else begin
      burst_q <= burst_d;
      wd_q    <= wd_d;
    end
  end

  assign wd_halt = wd_q;
`else
  logic unused_run_limit;
  assign unused_run_limit = ^RUN_LIMIT;
  assign wd_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HALT;
      skip_q  <= 1'b0;
      cyc_q   <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cyc_q   <= cyc_d;
      fetch_q <= fetch_d;
    end
  end

  assign halted      = (state_q == ST_HALT) | (state_q == ST_BREAK);
  assign bp_hit      = (state_q == ST_BREAK);
  assign cyc_count   = cyc_q;
  assign fetch_count = fetch_q;

endmodule

// File: tb/tb_pipe_run_controller.sv
// Scoreboard bench for pipe_run_controller: per-cycle expected control outputs are queued
// as stimulus is driven and compared at the falling edge; a small core model advances pc.
module tb_pipe_run_controller;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;
`ifdef RUN_WATCHDOG_EN
  localparam int unsigned LIMIT = 24;
`else
  localparam int unsigned LIMIT = 1024;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             step_req, run_req, clr_count, bp_en, stall_f;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_en, halted, bp_hit, wd_halt;
  logic [CNT_W-1:0] cyc_count, fetch_count;

  typedef struct packed {
    logic en;
    logic halted;
    logic bp_hit;
    logic wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_run_controller #(
    .PC_W      (PC_W),
    .CNT_W     (CNT_W),
    .RUN_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .step_req    (step_req),
    .run_req     (run_req),
    .clr_count   (clr_count),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .stall_f     (stall_f),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .wd_halt     (wd_halt),
    .cyc_count   (cyc_count),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Fetch stage stand-in: PC advances on every enabled, unstalled cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else if (cpu_en && !stall_f) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cpu_en",  32'(cpu_en),  32'(e.en));
      check("halted",  32'(halted),  32'(e.halted));
      check("bp_hit",  32'(bp_hit),  32'(e.bp_hit));
      check("wd_halt", 32'(wd_halt), 32'(e.wd));
    end
  end

  // Queue this cycle's expected outputs, then advance to just after the next edge
  task automatic tick(input logic en, input logic h, input logic b, input logic w = 1'b0);
    exp_q.push_back(exp_t'({en, h, b, w}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    step_req  = 1'b0;
    run_req   = 1'b0;
    clr_count = 1'b0;
    bp_en     = 1'b0;
    bp_addr   = '0;
    stall_f   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_bp_hit", 32'(bp_hit), 0);
    check("rst_wd",     32'(wd_halt), 0);
    check("rst_cyc",    32'(cyc_count), 0);
    check("rst_fetch",  32'(fetch_count), 0);
    reset_n = 1'b1;

    // Idle after reset
    repeat (10) tick(0, 1, 0);
    check("idle_cyc",   32'(cyc_count), 0);
    check("idle_fetch", 32'(fetch_count), 0);

    // Single step, no stall
    step_req = 1'b1; tick(0, 1, 0);
    step_req = 1'b0; tick(1, 0, 0);
    tick(0, 1, 0);
    check("step_cyc",   32'(cyc_count), 1);
    check("step_fetch", 32'(fetch_count), 1);
    check("step_pc",    pc, 32'h4);

    // Single step stretched by two stall cycles
    clr_count = 1'b1; tick(0, 1, 0);
    clr_count = 1'b0;
    check("clr_cyc", 32'(cyc_count), 0);
    step_req = 1'b1; tick(0, 1, 0);
    step_req = 1'b0; stall_f = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    stall_f = 1'b0;
    tick(1, 0, 0);
    tick(0, 1, 0);
    check("stall_cyc",   32'(cyc_count), 3);
    check("stall_fetch", 32'(fetch_count), 1);
    check("stall_pc",    pc, 32'h8);

    // Breakpoint at 0x10, then resume steps past it
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10;
    run_req = 1'b1; tick(0, 1, 0);
    run_req = 1'b0;
    repeat (4) tick(1, 0, 0);
    tick(0, 0, 0);
    check("bp_pc", pc, 32'h10);
    repeat (3) tick(0, 1, 1);
    check("bp_hold_pc", pc, 32'h10);
    run_req = 1'b1; tick(0, 1, 1);
    run_req = 1'b0;
    repeat (4) tick(1, 0, 0);
    check("resume_pc", pc, 32'h20);
    run_req = 1'b1; tick(1, 0, 0);
    run_req = 1'b0; tick(0, 1, 0);
    check("bp_run_pc",    pc, 32'h24);
    check("bp_run_cyc",   32'(cyc_count), 9);
    check("bp_run_fetch", 32'(fetch_count), 9);

    // bp_match with run_req -> BREAK; bp_en drop holds BREAK; step off the breakpoint
    do_reset();
    bp_addr = 32'h8;
    run_req = 1'b1; tick(0, 1, 0);
    run_req = 1'b0;
    repeat (2) tick(1, 0, 0);
    run_req = 1'b1; tick(0, 0, 0);
    run_req = 1'b0; tick(0, 1, 1);
    bp_en = 1'b0; tick(0, 1, 1);
    bp_en = 1'b1;
    step_req = 1'b1; tick(0, 1, 1);
    step_req = 1'b0; tick(1, 0, 0);
    tick(0, 1, 0);
    check("bp_step_pc", pc, 32'hC);

    // run_req+step_req in HALT -> RUN; clear during RUN; counter wrap
    do_reset();
    bp_en = 1'b0;
    run_req = 1'b1; step_req = 1'b1; tick(0, 1, 0);
    run_req = 1'b0; step_req = 1'b0;
    repeat (3) tick(1, 0, 0);
    clr_count = 1'b1; tick(1, 0, 0);
    clr_count = 1'b0;
    check("run_clr_cyc",   32'(cyc_count), 0);
    check("run_clr_fetch", 32'(fetch_count), 0);
    for (int i = 0; i < 17; i++) begin
      stall_f  = (i == 5 || i == 6);
      step_req = (i == 3);
      tick(1, 0, 0);
    end
    stall_f = 1'b0; step_req = 1'b0;
    check("wrap_cyc",   32'(cyc_count), 1);
    check("wrap_fetch", 32'(fetch_count), 15);
    run_req = 1'b1; tick(1, 0, 0);
    run_req = 1'b0; tick(0, 1, 0);
    check("halt_cyc",   32'(cyc_count), 2);
    check("halt_fetch", 32'(fetch_count), 0);

    // Asynchronous reset drops cpu_en mid-RUN and mid-STEP
    run_req = 1'b1; tick(0, 1, 0);
    run_req = 1'b0; tick(1, 0, 0);
    reset_n = 1'b0;
    #1;
    check("arst_run_en",  32'(cpu_en), 0);
    check("arst_run_hlt", 32'(halted), 1);
    check("arst_run_cyc", 32'(cyc_count), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step_req = 1'b1; tick(0, 1, 0);
    step_req = 1'b0; stall_f = 1'b1; tick(1, 0, 0);
    reset_n = 1'b0;
    #1;
    check("arst_step_en", 32'(cpu_en), 0);
    @(posedge clk); #1;
    reset_n = 1'b1; stall_f = 1'b0;
    tick(0, 1, 0);

`ifdef RUN_WATCHDOG_EN
    // Watchdog: exactly LIMIT enabled cycles, then a one-cycle wd_halt in HALT
    run_req = 1'b1; tick(0, 1, 0);
    run_req = 1'b0;
    repeat (LIMIT) tick(1, 0, 0, 0);
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 0);
    check("wd_cyc", 32'(cyc_count), LIMIT % 16);
`endif

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
